// File: rtl/sys_clkgen_pkg.sv
// Shared state encoding and config helpers for the multi-channel clock-enable generator.
// Helpers work on 32-bit words; callers cast down to CNT_W (CNT_W must be <= 32).
package sys_clkgen_pkg;

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  typedef logic [31:0] word_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic word_t clamp_div(input word_t div);
    return (div < word_t'(2)) ? word_t'(2) : div;
  endfunction

  function automatic word_t clamp_phase(input word_t ph, input word_t div);
    return (ph >= div) ? div - word_t'(1) : ph;
  endfunction

  // Counter start value that makes the first cnt==0 land ph cycles after ALIGN.
  function automatic word_t load_value(input word_t div, input word_t ph);
    return (ph == '0) ? '0 : div - ph;
  endfunction

endpackage

// File: rtl/sys_clkgen_chan.sv
// One output channel: shadow divide/phase registers, period counter and strobe decode.
module sys_clkgen_chan
  import sys_clkgen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEF_DIV   = 2,
  parameter int DEF_PHASE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_align,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_phase,
  output logic             o_outclk,
  output logic             o_outclk_en
);

  logic [CNT_W-1:0] r_div_s;
  logic [CNT_W-1:0] r_ph_s;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_div_new;
  logic [CNT_W-1:0] w_ph_new;
  logic [CNT_W-1:0] w_load;
  logic [CNT_W-1:0] w_high;
  logic [CNT_W-1:0] w_last;

  assign w_div_new = CNT_W'(clamp_div(word_t'(i_div)));
  // Phase is clamped against the divide ratio being written, not the old one.
  assign w_ph_new  = CNT_W'(clamp_phase(word_t'(i_phase), word_t'(w_div_new)));
  assign w_load    = CNT_W'(load_value(word_t'(r_div_s), word_t'(r_ph_s)));
  assign w_high    = CNT_W'((word_t'(r_div_s) + word_t'(1)) >> 1);
  assign w_last    = r_div_s - CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_s <= CNT_W'(DEF_DIV);
      r_ph_s  <= CNT_W'(DEF_PHASE);
      r_cnt   <= '0;
    end else begin
      if (i_wr) begin
        r_div_s <= w_div_new;
        r_ph_s  <= w_ph_new;
      end
      if (i_align) begin
        r_cnt <= w_load;
      end else if (i_run) begin
        r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_outclk    = i_run && (r_cnt < w_high);
  assign o_outclk_en = i_run && (r_cnt == '0);

endmodule

// File: rtl/sys_clkgen_nch.sv
// Multi-channel clock-enable generator: lock FSM, config handshake and channel array.
//   state  | meaning
//   ALIGN  | one cycle: load every channel counter to its phase offset, start running
//   SETTLE | counters run, lock counter counts toward LOCK_CYCLES
//   LOCKED | counters run, locked asserted
module sys_clkgen_nch
  import sys_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  parameter int DEF_PHASE   = 0,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int              LK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]   CH_LIM  = (CH_W + 1)'(NUM_CH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LK_W-1:0] r_lock_cnt;
  logic            r_run;

  logic              w_accept;
  logic              w_reconf;
  logic              w_align;
  logic [NUM_CH-1:0] w_wr;

  assign cfg_ready = (r_state != ALIGN) && !rst;
  assign locked    = (r_state == LOCKED);
  assign w_accept  = cfg_valid && cfg_ready;
  // Out-of-range channels complete the handshake but touch nothing.
  assign w_reconf  = w_accept && ({1'b0, cfg_chan} < CH_LIM);
  assign w_align   = (r_state == ALIGN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ALIGN:  w_state_nxt = SETTLE;
      SETTLE: begin
        if (w_reconf)                    w_state_nxt = ALIGN;
        else if (r_lock_cnt == LK_LAST)  w_state_nxt = LOCKED;
      end
      LOCKED: if (w_reconf) w_state_nxt = ALIGN;
      default: w_state_nxt = ALIGN;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state    <= ALIGN;
      r_lock_cnt <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ALIGN) begin
        r_run      <= 1'b1;
        r_lock_cnt <= '0;
      end else if (r_lock_cnt != LK_LAST) begin
        r_lock_cnt <= r_lock_cnt + LK_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    assign w_wr[g] = w_reconf && (cfg_chan == CH_W'(g));

    sys_clkgen_chan #(
      .CNT_W     (CNT_W),
      .DEF_DIV   (DEF_DIV),
      .DEF_PHASE (DEF_PHASE)
    ) u_chan (
      .i_clk       (refclk),
      .i_rst       (rst),
      .i_wr        (w_wr[g]),
      .i_align     (w_align),
      .i_run       (r_run),
      .i_div       (cfg_div),
      .i_phase     (cfg_phase),
      .o_outclk    (outclk[g]),
      .o_outclk_en (outclk_en[g])
    );
  end

endmodule

// File: tb/tb_sys_clkgen_nch.sv
// Self-checking bench: epoch-based reference model feeds a per-cycle expectation queue.
module tb_sys_clkgen_nch;
  import sys_clkgen_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int CNT_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int DEF_DIV     = 2;
  localparam int DEF_PHASE   = 0;
  localparam int CH_W        = ch_width(NUM_CH);

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outclk_en;
  logic              locked;

  sys_clkgen_nch #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES),
    .DEF_DIV(DEF_DIV), .DEF_PHASE(DEF_PHASE)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [NUM_CH-1:0] oc;
    logic [NUM_CH-1:0] en;
    logic              lk;
    bit                clk_care;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;

  state_t m_st;
  bit     m_run;
  int     m_k;
  int     m_div[NUM_CH];
  int     m_ph[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = ALIGN;
    m_run = 1'b0;
    m_k   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = DEF_DIV;
      m_ph[i]  = DEF_PHASE;
    end
  endtask

  task automatic model_edge(input logic r, input bit acc, input int ch, input int d, input int p);
    int nd;
    int np;
    bit reconf;
    if (r) begin
      model_reset();
    end else begin
      reconf = acc && (ch < NUM_CH);
      if (reconf) begin
        nd = (d < 2) ? 2 : d;
        np = (p >= nd) ? nd - 1 : p;
        m_div[ch] = nd;
        m_ph[ch]  = np;
      end
      case (m_st)
        ALIGN: begin
          m_st  = SETTLE;
          m_run = 1'b1;
          m_k   = 0;
        end
        SETTLE: begin
          if (reconf) m_st = ALIGN;
          else begin
            m_k++;
            if (m_k == LOCK_CYCLES) m_st = LOCKED;
          end
        end
        default: begin
          if (reconf) m_st = ALIGN;
          else m_k++;
        end
      endcase
    end
  endtask

  // Position within the period, measured from the common ALIGN epoch.
  function automatic exp_t model_out();
    exp_t e;
    int   pos;
    e.oc = '0;
    e.en = '0;
    e.lk = (m_st == LOCKED);
    e.clk_care = !(m_st == ALIGN && m_run);
    if (m_run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pos = (m_k + m_div[i] - m_ph[i]) % m_div[i];
        e.oc[i] = (pos < (m_div[i] + 1) / 2);
        e.en[i] = (pos == 0);
      end
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input int ch, input int d, input int p);
    bit   rdy_exp;
    exp_t e;
    rst       = r;
    cfg_valid = v;
    cfg_chan  = CH_W'(ch);
    cfg_div   = CNT_W'(d);
    cfg_phase = CNT_W'(p);
    #1;
    rdy_exp = (m_st != ALIGN) && !r;
    check("cfg_ready", 32'(cfg_ready), 32'(rdy_exp));
    @(posedge refclk);
    cyc++;
    model_edge(r, v && rdy_exp, ch, d, p);
    sb_q.push_back(model_out());
    @(negedge refclk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      check("locked", 32'(locked), 32'(e.lk));
      if (e.clk_care) begin
        check("outclk", 32'(outclk), 32'(e.oc));
        check("outclk_en", 32'(outclk_en), 32'(e.en));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_locked();
    for (int i = 0; i < 40 && m_st != LOCKED; i++) idle(1);
    if (m_st != LOCKED) check("lock_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    model_reset();
    @(posedge refclk);
    @(negedge refclk);

    // reset with a pending request: request must be dropped
    step(1'b1, 1'b1, 0, 7, 3);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(20);

    // ch1 div=5 phase=2 while locked
    wait_locked();
    step(1'b0, 1'b1, 1, 5, 2);
    idle(20);

    // ch1 back to div 2, then ch0 with out-of-range values (clamped to 2/1)
    wait_locked();
    step(1'b0, 1'b1, 1, 2, 0);
    wait_locked();
    step(1'b0, 1'b1, 0, 0, 9);
    idle(20);

    // out-of-range channel while locked: no realign
    wait_locked();
    step(1'b0, 1'b1, 3, 4, 1);
    idle(10);

    // request landing on the final SETTLE cycle
    step(1'b0, 1'b1, 2, 3, 1);
    for (int i = 0; i < 40 && !(m_st == SETTLE && m_k == LOCK_CYCLES - 1); i++) idle(1);
    if (!(m_st == SETTLE && m_k == LOCK_CYCLES - 1)) check("settle_timeout", 32'(0), 32'(1));
    step(1'b0, 1'b1, 0, 4, 1);
    idle(20);

    // reset mid-LOCKED after custom config, with a request present
    wait_locked();
    step(1'b0, 1'b1, 1, 7, 3);
    wait_locked();
    step(1'b1, 1'b1, 1, 9, 4);
    idle(22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
